// File: rtl/mux_4_1_rr_arbiter.sv
// Four-requester round-robin arbiter feeding a single registered output slot.
// Optional packet lock (`ARB_PKT_LOCK_EN`) keeps the grant on one requester until its last beat.
module mux_4_1_rr_arbiter #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel,
  input  logic           out_ready
`ifdef ARB_PKT_LOCK_EN
  ,
  input  logic [3:0]     in_last,
  output logic           out_last
`endif
);

  localparam int N = 4;

  logic       space;
  logic       found;
  logic       xfer;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic [1:0] idx;

`ifdef ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_t;
  lock_t      state;
  logic [1:0] lock_id;
`endif

  assign space = !out_valid || out_ready;

  // Scan starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 1; k <= N; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`ifdef ARB_PKT_LOCK_EN
    if (state == LOCKED) begin
      winner = lock_id;
      found  = in_valid[lock_id];
    end
`endif
  end

  assign xfer     = space && found;
  assign in_ready = xfer ? (4'b0001 << winner) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd3;
`ifdef ARB_PKT_LOCK_EN
      out_last  <= 1'b0;
      state     <= IDLE;
      lock_id   <= 2'd0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(winner)*W +: W];
      out_sel   <= winner;
`ifdef ARB_PKT_LOCK_EN
      out_last  <= in_last[winner];
      // Pointer advances only at packet end so the rotation is per packet, not per beat.
      if (in_last[winner]) begin
        ptr   <= winner;
        state <= IDLE;
      end else begin
        state   <= LOCKED;
        lock_id <= winner;
      end
`else
      ptr       <= winner;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Self-checking bench for mux_4_1_rr_arbiter: directed scenarios plus randomized
// traffic compared against a round-robin reference model (honours ARB_PKT_LOCK_EN).
module tb_mux_4_1_rr_arbiter;

  localparam int W = 4;
`ifdef ARB_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     in_valid = 4'h0;
  logic [4*W-1:0] in_data = '0;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready = 1'b0;
  logic [3:0]     in_last = 4'hF;
`ifdef ARB_PKT_LOCK_EN
  logic           out_last;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_last;
  bit           m_locked;
  int           m_lock_id;
  bit           m_out_last;

  mux_4_1_rr_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef ARB_PKT_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_valid    = 1'b0;
    m_data     = '0;
    m_sel      = 0;
    m_last     = 3;
    m_locked   = 1'b0;
    m_lock_id  = 0;
    m_out_last = 1'b0;
  endfunction

  function automatic int exp_winner();
    if (m_valid && !out_ready) return -1;
    if (LOCK_EN && m_locked) return in_valid[m_lock_id] ? m_lock_id : -1;
    for (int off = 1; off <= 4; off++) begin
      int i;
      i = (m_last + off) % 4;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    int w;
    r = 4'h0;
    w = exp_winner();
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic void model_step();
    int w;
    w = exp_winner();
    if (w >= 0) begin
      m_valid    = 1'b1;
      m_data     = in_data[w*W +: W];
      m_sel      = w;
      m_out_last = in_last[w];
      if (!LOCK_EN || in_last[w]) begin
        m_last   = w;
        m_locked = 1'b0;
      end else begin
        m_locked  = 1'b1;
        m_lock_id = w;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endfunction

  // Advances the model over the coming edge, then applies new inputs and waits to the sample point.
  task automatic cycle(input logic [3:0] v, input logic [4*W-1:0] d, input logic r, input logic [3:0] l);
    model_step();
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    in_last   = l;
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid  = 4'hF;
    in_data   = 16'h3210;
    out_ready = 1'b1;
    in_last   = 4'hF;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++;
    if (out_sel !== 2'd0) begin failures++; $display("FAIL reset_out_sel got=%0h exp=0", out_sel); end
`ifdef ARB_PKT_LOCK_EN
    checks++;
    if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0h exp=0", out_last); end
`endif
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    for (int k = 0; k < 8; k++) begin
      cycle(4'hF, 16'h3210, 1'b1, 4'hF);
      checks++;
      if (out_sel !== 2'(k % 4)) begin failures++; $display("FAIL fair_sel[%0d] got=%0d exp=%0d", k, out_sel, k % 4); end
      checks++;
      if (out_data !== 4'(k % 4)) begin failures++; $display("FAIL fair_data[%0d] got=%0h exp=%0h", k, out_data, k % 4); end
      checks++;
      if (in_ready !== exp_ready()) begin failures++; $display("FAIL fair_ready[%0d] got=%b exp=%b", k, in_ready, exp_ready()); end
    end
  endtask

  task automatic test_single();
    cycle(4'h0, 16'h0, 1'b1, 4'hF);
    cycle(4'b0100, 16'h0A00, 1'b1, 4'hF);
    checks++;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", in_ready); end
    cycle(4'h0, 16'h0, 1'b1, 4'hF);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd2) begin
      failures++; $display("FAIL single_out got=v%0h d%0h s%0d exp=v1 dA s2", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_stall();
    cycle(4'b0001, 16'h0003, 1'b1, 4'hF);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1010, 16'h7050, 1'b0, 4'hF);
      checks++;
      if (in_ready !== 4'h0) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=0000", k, in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'h3 || out_sel !== 2'd0) begin
        failures++; $display("FAIL stall_hold[%0d] got=v%0h d%0h s%0d exp=v1 d3 s0", k, out_valid, out_data, out_sel);
      end
    end
    cycle(4'b1010, 16'h7050, 1'b1, 4'hF);
    checks++;
    if (in_ready !== 4'b0010) begin failures++; $display("FAIL stall_rel_ready got=%b exp=0010", in_ready); end
    cycle(4'b1010, 16'h7050, 1'b1, 4'hF);
    checks++;
    if (out_sel !== 2'd1 || out_data !== 4'h5) begin failures++; $display("FAIL stall_first got=s%0d d%0h exp=s1 d5", out_sel, out_data); end
    cycle(4'b0000, 16'h7050, 1'b1, 4'hF);
    checks++;
    if (out_sel !== 2'd3 || out_data !== 4'h7) begin failures++; $display("FAIL stall_second got=s%0d d%0h exp=s3 d7", out_sel, out_data); end
  endtask

  task automatic test_back_to_back();
    cycle(4'b0100, 16'h0500, 1'b1, 4'hF);
    cycle(4'b0100, 16'h0600, 1'b1, 4'hF);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h5) begin failures++; $display("FAIL b2b_first got=v%0h d%0h exp=v1 d5", out_valid, out_data); end
    cycle(4'b0000, 16'h0000, 1'b1, 4'hF);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h6) begin failures++; $display("FAIL b2b_second got=v%0h d%0h exp=v1 d6", out_valid, out_data); end
    cycle(4'b0000, 16'h0000, 1'b1, 4'hF);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h6) begin failures++; $display("FAIL b2b_drain got=v%0h d%0h exp=v0 d6", out_valid, out_data); end
  endtask

  task automatic test_reset_mid();
    cycle(4'b0001, 16'h0009, 1'b0, 4'hF);
    cycle(4'b0000, 16'h0000, 1'b0, 4'hF);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0h exp=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0) begin
      failures++; $display("FAIL rmid_async got=v%0h d%0h s%0d exp=v0 d0 s0", out_valid, out_data, out_sel);
    end
    in_valid  = 4'hF;
    in_data   = 16'h4321;
    out_ready = 1'b1;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    cycle(4'h0, 16'h0, 1'b1, 4'hF);
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h1) begin
      failures++; $display("FAIL rmid_first got=v%0h s%0d d%0h exp=v1 s0 d1", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_packet();
    int exp_sel[4];
    if (LOCK_EN) exp_sel = '{0, 0, 0, 1};
    else         exp_sel = '{0, 1, 0, 1};
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    in_valid  = 4'b0011;
    in_data   = 16'h00B1;
    out_ready = 1'b1;
    in_last   = 4'b1110;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(4'b0011, 16'h00B1, 1'b1, (k == 1) ? 4'b1111 : 4'b1110);
      checks++;
      if (out_sel !== 2'(exp_sel[k])) begin failures++; $display("FAIL pkt_sel[%0d] got=%0d exp=%0d", k, out_sel, exp_sel[k]); end
    end
  endtask

  task automatic test_random();
    logic [3:0] onehot_bad;
    for (int k = 0; k < 400; k++) begin
      cycle(4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      checks++;
      if (in_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", k, in_ready, exp_ready()); end
      onehot_bad = in_ready & (in_ready - 4'd1);
      checks++;
      if (onehot_bad !== 4'h0 || (in_ready & ~in_valid) !== 4'h0) begin
        failures++; $display("FAIL rnd_onehot[%0d] got=%b valid=%b", k, in_ready, in_valid);
      end
      checks++;
      if (out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%0h exp=%0h", k, out_valid, m_valid); end
      checks++;
      if (out_data !== m_data || out_sel !== 2'(m_sel)) begin
        failures++; $display("FAIL rnd_out[%0d] got=d%0h s%0d exp=d%0h s%0d", k, out_data, out_sel, m_data, m_sel);
      end
`ifdef ARB_PKT_LOCK_EN
      checks++;
      if (out_last !== m_out_last) begin failures++; $display("FAIL rnd_last[%0d] got=%0h exp=%0h", k, out_last, m_out_last); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
